// File: rtl/buffer_reg_pkg.sv
// Shared defaults and helpers for the buffer_reg_fifo register-bank FIFO.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package buffer_reg_pkg;

  localparam int BUFREG_DEF_WIDTH = 4;
  localparam int BUFREG_DEF_DEPTH = 4;

  // Count must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/buffer_reg_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and an async read port.
// Latency: write lands on posedge clk; read is combinational from raddr.
// Backpressure: none; the caller decides when we is asserted. Storage is not reset.
module buffer_reg_mem
  import buffer_reg_pkg::*;
#(
  parameter int WIDTH = BUFREG_DEF_WIDTH,
  parameter int DEPTH = BUFREG_DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed word on the clock edge; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/buffer_reg_fifo.sv
// DEPTH-entry WIDTH-bit FIFO buffer register bank with valid/ready on both sides, count and flush.
// Latency: 1 cycle when empty; 0 cycles via fall-through when BUFFER_REG_BYPASS_EN is defined.
// Backpressure: in_ready = !full only (no combinational path from out_ready); clr wins over push/pop.
module buffer_reg_fifo
  import buffer_reg_pkg::*;
#(
  parameter int WIDTH = BUFREG_DEF_WIDTH,
  parameter int DEPTH = BUFREG_DEF_DEPTH,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push;
  logic             pop;
  logic             we;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

  // pop means "a stored word leaves"; a bypassed word never touches the array.
  assign pop = !empty & out_ready;

`ifdef BUFFER_REG_BYPASS_EN
  logic bypass;
  // Empty and consumer ready: hand the word straight through without storing it.
  assign bypass    = empty & in_valid & out_ready;
  assign out_valid = empty ? in_valid : 1'b1;
  assign out_data  = !empty ? rdata : (in_valid ? in_data : '0);
  assign push      = in_valid & in_ready & !bypass;
`else
  assign out_valid = !empty;
  assign out_data  = out_valid ? rdata : '0;
  assign push      = in_valid & in_ready;
`endif

  assign we = push & !clr;

  buffer_reg_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy update; flush discards any same-cycle transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reg_fifo.sv
// Self-checking bench for buffer_reg_fifo (default build or BUFFER_REG_BYPASS_EN).
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later and 1ns after the edge.
// Backpressure: a queue model tracks stored words; in_ready/full derive from its size.
module tb_buffer_reg_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef BUFFER_REG_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] q[$];

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             ov;
    logic [WIDTH-1:0] od;
    logic [CW-1:0]    cnt;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  buffer_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the queue model, update the model, clock.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic c,
                     output logic s_ov, output logic [WIDTH-1:0] s_od);
    logic             byp;
    logic             exp_ov;
    logic [WIDTH-1:0] exp_od;
    logic             pushed;
    logic [WIDTH-1:0] head;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
    byp    = BYP && (q.size() == 0) && iv;
    exp_ov = (q.size() != 0) || byp;
    exp_od = (q.size() != 0) ? q[0] : (byp ? d : '0);
    s_ov   = out_valid;
    s_od   = out_data;
    check("count",     32'(count),     32'(q.size()));
    check("full",      32'(full),      32'(q.size() == DEPTH));
    check("empty",     32'(empty),     32'(q.size() == 0));
    check("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("out_data",  32'(out_data),  32'(exp_od));
    if (c) begin
      q.delete();
    end else begin
      pushed = iv && (q.size() != DEPTH) && !(byp && ordy);
      if (q.size() != 0 && ordy) head = q.pop_front();
      if (pushed) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             ov;
    logic [WIDTH-1:0] od;

    // Fill to full, attempt a 5th push, drain in order, then pop on empty.
    tbl[0] = '{1'b1, 4'h1, 1'b0, BYP, (BYP ? 4'h1 : 4'h0), 3'd1};
    tbl[1] = '{1'b1, 4'h2, 1'b0, 1'b1, 4'h1, 3'd2};
    tbl[2] = '{1'b1, 4'h3, 1'b0, 1'b1, 4'h1, 3'd3};
    tbl[3] = '{1'b1, 4'h4, 1'b0, 1'b1, 4'h1, 3'd4};
    tbl[4] = '{1'b1, 4'hF, 1'b0, 1'b1, 4'h1, 3'd4};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 3'd3};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 3'd2};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 3'd1};
    tbl[8] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 3'd0};
    tbl[9] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0};

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0, ov, od);
      check("tbl_out_valid", 32'(ov),    32'(tbl[i].ov));
      check("tbl_out_data",  32'(od),    32'(tbl[i].od));
      check("tbl_count",     32'(count), 32'(tbl[i].cnt));
    end

    // Simultaneous push/pop at count 2; pointers wrap past DEPTH-1.
    cyc(1'b1, 4'h8, 1'b0, 1'b0, ov, od);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, ov, od);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 4'(4'hA + i), 1'b1, 1'b0, ov, od);
      check("pp_out_data", 32'(od),    (i < 2) ? 32'(8 + i) : 32'(10 + i - 2));
      check("pp_count",    32'(count), 32'd2);
    end

    // Full plus pop: pop happens, push rejected, then accepted next cycle.
    cyc(1'b1, 4'h1, 1'b0, 1'b0, ov, od);
    cyc(1'b1, 4'h2, 1'b0, 1'b0, ov, od);
    check("fp_full", 32'(full), 32'd1);
    cyc(1'b1, 4'h9, 1'b1, 1'b0, ov, od);
    check("fp_pop_data", 32'(od),       32'hE);
    check("fp_count",    32'(count),    32'd3);
    check("fp_in_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 4'h9, 1'b0, 1'b0, ov, od);
    check("fp_accept_count", 32'(count), 32'd4);

    // clr priority at count 3 with push and pop requested.
    cyc(1'b0, 4'h0, 1'b1, 1'b0, ov, od);
    check("clr_pre_count", 32'(count), 32'd3);
    cyc(1'b1, 4'h5, 1'b1, 1'b1, ov, od);
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    cyc(1'b1, 4'h7, 1'b0, 1'b0, ov, od);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, ov, od);
    check("clr_first_word", 32'(od), 32'h7);

    // Empty-buffer transfer: fall-through with the macro, one-cycle latency without.
    cyc(1'b1, 4'hC, 1'b1, 1'b0, ov, od);
    check("byp_out_valid", 32'(ov), 32'(BYP));
    check("byp_out_data",  32'(od), BYP ? 32'hC : 32'h0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("byp_after_count", 32'(count),    BYP ? 32'd0 : 32'd1);
    check("byp_after_data",  32'(out_data), BYP ? 32'h0 : 32'hC);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, ov, od);

    // Asynchronous reset mid-traffic.
    cyc(1'b1, 4'h3, 1'b0, 1'b0, ov, od);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, ov, od);
    in_valid = 1'b0;
    #1;
    check("mr_pre_count", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    check("mr_count",     32'(count),     32'd0);
    check("mr_empty",     32'(empty),     32'd1);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data",  32'(out_data),  32'd0);
    check("mr_in_ready",  32'(in_ready),  32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 4'h6, 1'b0, 1'b0, ov, od);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, ov, od);
    check("post_rst_word", 32'(od), 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_reg_fifo.md
Name: buffer_reg_fifo

Overview:
- Parametrised successor to the 4-bit D-flip-flop buffer register: a DEPTH-entry, WIDTH-bit controlled buffer register bank.
- Valid/ready handshake on both sides; occupancy count and synchronous flush.
- Sits between a producer and consumer that cannot guarantee same-cycle transfer, decoupling them by up to DEPTH words.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- CW, $clog2(DEPTH)+1, count width (derived; not overridden).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  asynchronous active-low reset. Asserting clears state immediately; deassertion is synchronous to clk upstream.
- clr  input  1  synchronous flush, active-high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  write data.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  WIDTH  read data.
- count  output  CW  number of stored words, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, out_valid=0, in_ready=1, out_data=0.
  - Storage array is not reset.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on posedge clk.
- Output signals:
  - in_ready = !full. It does not depend on out_ready, so there is no combinational ready path.
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when out_valid=1, else 0 (combinational read of the registered array).
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N (1-cycle latency) when the buffer was empty.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural wrap, DEPTH is a power of two).
- Pop: rd_ptr increments modulo DEPTH.
- Count:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0. in_valid is ignored and data is not written. A pop in that cycle still occurs, and in_ready returns to 1 the next cycle.
- Empty: out_valid=0. out_ready is ignored and no pointer moves.
- clr=1:
  - Next edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the same cycle is discarded; clr has priority.
- Reset mid-operation: all stored words are lost and outputs go to reset values asynchronously, regardless of in-flight handshakes.
- Ordering: strictly FIFO. No word is duplicated or dropped except through clr or rst.

Optional Feature:
- Macro: BUFFER_REG_BYPASS_EN.
- Defined:
  - When empty=1, out_valid = in_valid and out_data = in_data (combinational fall-through).
  - If out_ready=1 in that cycle, the word is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the word is written normally.
  - clr still suppresses the transfer.
  - Latency in the empty case becomes 0 cycles.
- Undefined: behaviour exactly as above, with 1-cycle minimum latency and no combinational in→out path.

Decomposition:
- Package buffer_reg_pkg holds:
  - constants BUFREG_DEF_WIDTH=4 and BUFREG_DEF_DEPTH=4.
  - a function for the count width.
- One natural sub-module, buffer_reg_mem:
  - DEPTH×WIDTH register array.
  - Write port: we, waddr, wdata on posedge clk.
  - Asynchronous read port: raddr, rdata.
  - No reset.
- Pointer, count and handshake control stays in buffer_reg_fifo.

Test Plan:
- Reset mid-traffic: push 4'h3 and 4'h5, drive rst=0 between edges → outputs go immediately to count=0, empty=1, out_valid=0, out_data=0, in_ready=1.
- Fill/drain, out_ready=0: push 4'h1, 4'h2, 4'h3, 4'h4 → count=4, full=1, in_ready=0. A 5th push of 4'hF is ignored. Then out_ready=1 for 4 cycles → out_data 1,2,3,4 in order, then empty=1.
- Simultaneous push/pop at count=2: in_valid=1, out_ready=1 for 6 cycles with data 4'hA..4'hF → count stays 2 and outputs arrive in order. Pointers wrap past DEPTH-1 without corruption.
- Full plus pop: at count=4 assert in_valid with 4'h9 and out_ready=1 → pop occurs, push rejected, count=3. Next cycle in_ready=1 and 4'h9 is accepted.
- clr priority: at count=3 assert clr with in_valid=1 and out_ready=1 → next edge count=0, empty=1. Subsequent push of 4'h7 emerges as the first word.
- BUFFER_REG_BYPASS_EN: empty, in_valid=1, in_data=4'hC, out_ready=1 → out_valid=1 and out_data=4'hC in the same cycle, count stays 0. Without the macro: out_valid=0 that cycle, 4'hC appears after the edge.
